// File: rtl/serial_compare_ctrl.sv
// Bit-serial 8-bit magnitude comparator with nibble-wise operand capture
// from a switch bus and strobe-driven start/result handshake.
//
// state   | meaning
// IDLE    | operands loadable, waiting for a start event
// COMPARE | scanning bit pairs MSB-first, one per clock; loads ignored
// DONE    | less/more/equal valid; a load returns to IDLE, a start restarts
module serial_compare_ctrl #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Y,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       less,
  output logic       more,
  output logic       equal
);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] a, b;
  logic [2:0] idx;
  logic       lt, gt;
  logic       p1, p2, p3, p4, ps;
  logic       ev1, ev2, ev3, ev4, ev_start, ev_load, load_ok;
  logic       bit_a, bit_b, lt_nxt, gt_nxt, fin;
  logic       busy_nxt, done_nxt, less_nxt, more_nxt, equal_nxt;

  // rising-edge events: a held strobe fires once until sampled low again
  assign ev1      = PB1 & ~p1;
  assign ev2      = PB2 & ~p2;
  assign ev3      = PB3 & ~p3;
  assign ev4      = PB4 & ~p4;
  assign ev_start = start & ~ps;
  assign ev_load  = ev1 | ev2 | ev3 | ev4;
  assign load_ok  = (state != COMPARE);

  always_comb begin
    bit_a  = a[idx];
    bit_b  = b[idx];
    lt_nxt = lt | (~lt & ~gt & ~bit_a & bit_b);
    gt_nxt = gt | (~lt & ~gt & bit_a & ~bit_b);
    fin    = (idx == 3'd0) | (EARLY_EXIT & (lt_nxt | gt_nxt));
  end

  // state register plus datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= 8'h00;
      b     <= 8'h00;
      idx   <= 3'd7;
      lt    <= 1'b0;
      gt    <= 1'b0;
      p1    <= 1'b0;
      p2    <= 1'b0;
      p3    <= 1'b0;
      p4    <= 1'b0;
      ps    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      less  <= 1'b0;
      more  <= 1'b0;
      equal <= 1'b0;
    end else begin
      state <= state_nxt;
      p1    <= PB1;
      p2    <= PB2;
      p3    <= PB3;
      p4    <= PB4;
      ps    <= start;
      busy  <= busy_nxt;
      done  <= done_nxt;
      less  <= less_nxt;
      more  <= more_nxt;
      equal <= equal_nxt;
      if (load_ok) begin
        if (ev1) a[3:0] <= Y;
        if (ev2) a[7:4] <= Y;
        if (ev3) b[3:0] <= Y;
        if (ev4) b[7:4] <= Y;
        if (ev_start) begin
          idx <= 3'd7;
          lt  <= 1'b0;
          gt  <= 1'b0;
        end
      end else begin
        lt <= lt_nxt;
        gt <= gt_nxt;
        if (!fin) idx <= idx - 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ev_start) state_nxt = COMPARE;
      COMPARE: if (fin) state_nxt = DONE;
      DONE: begin
        if (ev_start)     state_nxt = COMPARE;
        else if (ev_load) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt  = busy;
    done_nxt  = done;
    less_nxt  = less;
    more_nxt  = more;
    equal_nxt = equal;
    if (load_ok && ev_start) begin
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      less_nxt  = 1'b0;
      more_nxt  = 1'b0;
      equal_nxt = 1'b0;
    end else if (state == DONE && ev_load) begin
      done_nxt  = 1'b0;
      less_nxt  = 1'b0;
      more_nxt  = 1'b0;
      equal_nxt = 1'b0;
    end else if (state == COMPARE && fin) begin
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
      less_nxt  = lt_nxt;
      more_nxt  = gt_nxt;
      equal_nxt = ~(lt_nxt | gt_nxt);
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed plus randomized bench for serial_compare_ctrl; runs an early-exit
// and a full-scan instance side by side against a magnitude/latency model.
module tb_serial_compare_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Y;
  logic       PB1, PB2, PB3, PB4, start;
  logic       busy1, done1, less1, more1, equal1;
  logic       busy0, done0, less0, more0, equal0;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] ma, mb;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .Y(Y), .PB1(PB1), .PB2(PB2), .PB3(PB3), .PB4(PB4),
    .start(start), .busy(busy1), .done(done1), .less(less1), .more(more1),
    .equal(equal1));

  serial_compare_ctrl #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .Y(Y), .PB1(PB1), .PB2(PB2), .PB3(PB3), .PB4(PB4),
    .start(start), .busy(busy0), .done(done0), .less(less0), .more(more0),
    .equal(equal0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " dut1 outs"}, {busy1, done1, less1, more1, equal1}, 5'b0);
    chk({tag, " dut0 outs"}, {busy0, done0, less0, more0, equal0}, 5'b0);
  endtask

  task automatic load_a(input logic [7:0] v);
    Y = v[3:0]; PB1 = 1'b1; tick(); PB1 = 1'b0;
    Y = v[7:4]; PB2 = 1'b1; tick(); PB2 = 1'b0;
    ma = v;
  endtask

  task automatic load_b(input logic [7:0] v);
    Y = v[7:4]; PB4 = 1'b1; tick(); PB4 = 1'b0;
    Y = v[3:0]; PB3 = 1'b1; tick(); PB3 = 1'b0;
    mb = v;
  endtask

  // pbm: strobes fired together with start (bit0=PB1..bit3=PB4), loading ynib.
  // disturb: edge number after start at which PB1(Y=F)+start are pulsed.
  task automatic run_compare(input logic [3:0] pbm, input logic [3:0] ynib, input int disturb,
                             input string tag);
    int k;
    int lat1;
    logic [7:0] diff;
    Y = ynib;
    {PB4, PB3, PB2, PB1} = pbm;
    start = 1'b1;
    if (pbm[0]) ma[3:0] = ynib;
    if (pbm[1]) ma[7:4] = ynib;
    if (pbm[2]) mb[3:0] = ynib;
    if (pbm[3]) mb[7:4] = ynib;
    tick();
    {PB4, PB3, PB2, PB1} = 4'b0;
    start = 1'b0;
    diff = ma ^ mb;
    k = -1;
    for (int i = 7; i >= 0; i--) if (diff[i] && k < 0) k = i;
    lat1 = (k < 0) ? 8 : 8 - k;
    chk({tag, " busy1 at T"}, {busy1, done1}, 2'b10);
    chk({tag, " busy0 at T"}, {busy0, done0}, 2'b10);
    for (int n = 1; n <= 10; n++) begin
      if (n == disturb) begin
        Y = 4'hF; PB1 = 1'b1; start = 1'b1;
      end
      tick();
      PB1 = 1'b0; start = 1'b0;
      chk($sformatf("%s dut1 busy/done T+%0d", tag, n), {busy1, done1},
          {n < lat1, n >= lat1});
      chk($sformatf("%s dut0 busy/done T+%0d", tag, n), {busy0, done0},
          {n < 8, n >= 8});
    end
    chk({tag, " dut1 flags"}, {less1, more1, equal1}, {ma < mb, ma > mb, ma == mb});
    chk({tag, " dut0 flags"}, {less0, more0, equal0}, {ma < mb, ma > mb, ma == mb});
  endtask

  initial begin
    int rises1, rises0;
    logic pb1_prev, pb0_prev;
    rst = 1'b1; Y = 4'h0; PB1 = 1'b0; PB2 = 1'b0; PB3 = 1'b0; PB4 = 1'b0; start = 1'b0;
    ma = 8'h00; mb = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_idle_outputs("reset");
    run_compare(4'b0, 4'h0, 0, "zero");

    load_a(8'hA5); load_b(8'hA3);
    run_compare(4'b0, 4'h0, 0, "A5vA3");

    load_a(8'h00); load_b(8'h80);
    run_compare(4'b0, 4'h0, 0, "00v80");

    // held start must produce exactly one restart
    rises1 = 0; rises0 = 0;
    pb1_prev = busy1; pb0_prev = busy0;
    start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (busy1 && !pb1_prev) rises1++;
      if (busy0 && !pb0_prev) rises0++;
      pb1_prev = busy1; pb0_prev = busy0;
    end
    start = 1'b0;
    tick();
    chk("held start dut1 restarts", rises1, 1);
    chk("held start dut0 restarts", rises0, 1);
    chk("held start dut1 result", {done1, less1, more1, equal1}, 4'b1100);
    chk("held start dut0 result", {done0, less0, more0, equal0}, 4'b1100);

    load_a(8'h3C); load_b(8'h3C);
    run_compare(4'b0, 4'h0, 3, "ignore in compare");
    Y = 4'hF; PB1 = 1'b1; tick(); PB1 = 1'b0;
    ma[3:0] = 4'hF;
    chk("load in DONE dut1", {busy1, done1, less1, more1, equal1}, 5'b0);
    chk("load in DONE dut0", {busy0, done0, less0, more0, equal0}, 5'b0);
    run_compare(4'b0, 4'h0, 0, "3Fv3C");

    load_a(8'h0F); load_b(8'hF0);
    run_compare(4'b0010, 4'hF, 0, "load+start");

    load_a(8'h5A); load_b(8'h5B);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    ma = 8'h00; mb = 8'h00;
    chk_idle_outputs("mid reset");
    tick();
    chk_idle_outputs("after reset");
    run_compare(4'b0, 4'h0, 0, "post reset");

    for (int it = 0; it < 16; it++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        load_a(ra); load_b(rb);
      end else begin
        load_b(rb); load_a(ra);
      end
      run_compare(4'b0, 4'h0, 0, $sformatf("rand%0d %02h v %02h", it, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
- Sequencing controller for the 8-bit magnitude comparison in the lab board flow.
- Captures two 8-bit operands nibble-by-nibble from the 4-bit switch bus via pushbutton strobes.
- On a start strobe, runs an MSB-first bit-serial comparison with an FSM, one bit per clock.
- Presents registered less/more/equal flags with a done indication, replacing the purely combinational ripple chain with a clocked, handshaked unit.

Parameters:
- EARLY_EXIT, default 1: 1 = finish on the first differing bit; 0 = always scan all 8 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- Y  input  4  operand nibble data (switches)
- PB1  input  1  load strobe: a[3:0] <= Y
- PB2  input  1  load strobe: a[7:4] <= Y
- PB3  input  1  load strobe: b[3:0] <= Y
- PB4  input  1  load strobe: b[7:4] <= Y
- start  input  1  comparison request strobe
- busy  output  1  high while comparing
- done  output  1  result valid
- less  output  1  a < b (unsigned), valid when done
- more  output  1  a > b (unsigned), valid when done
- equal  output  1  a == b, valid when done

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; a=b=0; idx=7; busy=done=less=more=equal=0; edge-detect history regs cleared to 0.
- Strobe edge detect: per input (PB1-4, start), history reg p <= input each clock. An event fires at an edge where input=1 and p=0. A held-high input fires once; re-arm requires one low sample.
- States: IDLE, COMPARE, DONE.
- Loads:
  - Honoured in IDLE and DONE; ignored in COMPARE. The event is consumed, not queued.
  - The nibble is written at the same edge the event fires.
  - Multiple PB events in one cycle each write their own nibble.
  - A load in DONE moves to IDLE and clears done/less/more/equal to 0.
- IDLE/DONE + start event -> COMPARE:
  - idx=7, lt=gt=0, busy=1, done=less=more=equal=0.
  - A load and start firing at the same edge: the load is written, and the comparison uses the new value, because bit reads begin at the next edge.
- COMPARE, per edge, with bit pair (a[idx], b[idx]):
  - If lt=gt=0 and a=1,b=0: set gt. If lt=gt=0 and a=0,b=1: set lt. Once lt or gt is set, later bits do not change it.
  - EARLY_EXIT=1: on the edge that sets lt/gt, go to DONE.
  - Otherwise decrement idx. The edge processing idx=0 goes to DONE.
  - idx never wraps below 0.
- Entering DONE (registered at the transition edge):
  - busy=0, done=1.
  - less=lt_next, more=gt_next, equal=!(lt_next|gt_next).
  - Exactly one of less/more/equal is high.
  - Outputs hold until a start event, a load event, or rst.
- Start event in COMPARE: ignored.
- Start event in DONE: restarts immediately with the held operands.
- Latency, counting edge T as the edge where the start event fires:
  - EARLY_EXIT=0: bits 7..0 are processed at edges T+1..T+8; done=1 after edge T+8.
  - EARLY_EXIT=1: first difference at bit k sets done after edge T+(8-k); equal operands take T+8.
- Reset mid-COMPARE: abandons the operation. All registers take reset values and the operands are lost.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- rst high 2 cycles, then low -> busy=done=less=more=equal=0. Start event with a=b=0 -> done after 8 edges, equal=1.
- Load a=0xA5 (PB1 Y=5, PB2 Y=A), b=0xA3 (PB3 Y=3, PB4 Y=A), start, EARLY_EXIT=1 -> busy for 6 edges (bits 7..2). Done after edge T+6 with more=1, less=0, equal=0. With EARLY_EXIT=0, same result after edge T+8.
- a=0x00, b=0x80, start, EARLY_EXIT=1 -> done after edge T+1, less=1. Then hold start high 20 cycles -> exactly one restart.
- During COMPARE with a=b=0x3C, pulse PB1 with Y=F and pulse start -> a stays 0x3C, no restart, equal=1 at T+8. A following PB1 in DONE -> done=0, a[3:0]=F.
- PB2 (Y=0xF) and start fire at the same edge with a=0x0F, b=0xF0 -> a becomes 0xFF, and the compare yields more=1.
- Assert rst at T+3 of a compare -> next cycle state IDLE, a=b=0, all outputs 0. A subsequent start event yields equal=1.
